// File: rtl/dataplane_axil_regs.sv
// AXI4-Lite slave register bank: ID, SCRATCH, CTRL, STATUS and WR_COUNT registers
// with independent write (AW/W/B) and read (AR/R) paths.
module dataplane_axil_regs #(
  parameter int          ADDR_W   = 32,
  parameter int          CTRL_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'hD47A_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  input  logic [31:0]       status_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  localparam logic [5:0] IDX_ID       = 6'd0;
  localparam logic [5:0] IDX_SCRATCH  = 6'd1;
  localparam logic [5:0] IDX_CTRL     = 6'd2;
  localparam logic [5:0] IDX_STATUS   = 6'd3;
  localparam logic [5:0] IDX_WR_COUNT = 6'd4;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  w_state_t          w_state_reg, w_state_next;
  r_state_t          r_state_reg, r_state_next;
  logic              aw_held_reg, aw_held_next, w_held_reg, w_held_next;
  logic              awready_reg, awready_next, wready_reg, wready_next;
  logic              bvalid_reg, bvalid_next;
  logic [1:0]        bresp_reg, bresp_next;
  logic              arready_reg, arready_next, rvalid_reg, rvalid_next;
  logic [1:0]        rresp_reg, rresp_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic [5:0]        aw_idx_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic [31:0]       scratch_reg, wr_count_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  logic              aw_hs, w_hs, ar_hs, do_write, wr_ok, rd_err;
  logic [5:0]        wr_idx;
  logic [31:0]       wr_data, scratch_merged, rd_word, ctrl_ext;
  logic [3:0]        wr_strb;
  logic [CTRL_W-1:0] ctrl_merged;
  logic              unused_addr_bits;

  assign aw_hs    = s_axil_awvalid && awready_reg;
  assign w_hs     = s_axil_wvalid && wready_reg;
  assign ar_hs    = s_axil_arvalid && arready_reg;
  // A channel accepted this cycle is used directly, so the write can execute on the handshake itself
  assign wr_idx   = aw_held_reg ? aw_idx_reg : s_axil_awaddr[7:2];
  assign wr_data  = w_held_reg ? wdata_reg : s_axil_wdata;
  assign wr_strb  = w_held_reg ? wstrb_reg : s_axil_wstrb;
  assign do_write = (w_state_reg == W_IDLE) && (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
  assign wr_ok    = (wr_idx == IDX_SCRATCH) || (wr_idx == IDX_CTRL);
  assign ctrl_ext = 32'(ctrl_reg);
  assign unused_addr_bits = ^{s_axil_awaddr[ADDR_W-1:8], s_axil_awaddr[1:0],
                              s_axil_araddr[ADDR_W-1:8], s_axil_araddr[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scratch_byte
      assign scratch_merged[8*gi +: 8] = wr_strb[gi] ? wr_data[8*gi +: 8] : scratch_reg[8*gi +: 8];
    end
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_bit
      assign ctrl_merged[gi] = wr_strb[gi/8] ? wr_data[gi] : ctrl_reg[gi];
    end
  endgenerate

  always_comb begin
    w_state_next = w_state_reg;
    aw_held_next = aw_held_reg || aw_hs;
    w_held_next  = w_held_reg || w_hs;
    bvalid_next  = bvalid_reg;
    bresp_next   = bresp_reg;
    case (w_state_reg)
      W_IDLE: begin
        if (do_write) begin
          w_state_next = W_RESP;
          aw_held_next = 1'b0;
          w_held_next  = 1'b0;
          bvalid_next  = 1'b1;
          bresp_next   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          w_state_next = W_IDLE;
          bvalid_next  = 1'b0;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
    awready_next = (w_state_next == W_IDLE) && !aw_held_next;
    wready_next  = (w_state_next == W_IDLE) && !w_held_next;
  end

  always_comb begin
    rd_word = 32'd0;
    rd_err  = 1'b0;
    case (s_axil_araddr[7:2])
      IDX_ID:       rd_word = ID_VALUE;
      IDX_SCRATCH:  rd_word = scratch_reg;
      IDX_CTRL:     rd_word = ctrl_ext;
      IDX_STATUS:   rd_word = status_i;
      IDX_WR_COUNT: rd_word = wr_count_reg;
      default:      rd_err  = 1'b1;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    rvalid_next  = rvalid_reg;
    rdata_next   = rdata_reg;
    rresp_next   = rresp_reg;
    case (r_state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_next = R_DATA;
          rvalid_next  = 1'b1;
          rdata_next   = rd_word;
          rresp_next   = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA: begin
        if (s_axil_rready) begin
          r_state_next = R_IDLE;
          rvalid_next  = 1'b0;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
    arready_next = (r_state_next == R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= 2'b00;
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= 32'd0;
      rresp_reg   <= 2'b00;
    end else begin
      w_state_reg <= w_state_next;
      aw_held_reg <= aw_held_next;
      w_held_reg  <= w_held_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
      r_state_reg <= r_state_next;
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      rdata_reg   <= rdata_next;
      rresp_reg   <= rresp_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_idx_reg   <= 6'd0;
      wdata_reg    <= 32'd0;
      wstrb_reg    <= 4'd0;
      scratch_reg  <= 32'd0;
      ctrl_reg     <= '0;
      wr_count_reg <= 32'd0;
    end else begin
      if (aw_hs) aw_idx_reg <= s_axil_awaddr[7:2];
      if (w_hs) begin
        wdata_reg <= s_axil_wdata;
        wstrb_reg <= s_axil_wstrb;
      end
      if (do_write && wr_ok) begin
        if (wr_idx == IDX_SCRATCH) scratch_reg <= scratch_merged;
        if (wr_idx == IDX_CTRL)    ctrl_reg    <= ctrl_merged;
        wr_count_reg <= wr_count_reg + 32'd1;
      end
    end
  end

  assign s_axil_awready = awready_reg;
  assign s_axil_wready  = wready_reg;
  assign s_axil_bvalid  = bvalid_reg;
  assign s_axil_bresp   = bresp_reg;
  assign s_axil_arready = arready_reg;
  assign s_axil_rvalid  = rvalid_reg;
  assign s_axil_rdata   = rdata_reg;
  assign s_axil_rresp   = rresp_reg;
  assign ctrl_o         = ctrl_reg;

endmodule

// File: tb/tb_dataplane_axil_regs.sv
// Directed plus randomized bench for dataplane_axil_regs, checked against a
// register-map model held as plain variables.
module tb_dataplane_axil_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata, status_i;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [7:0]  ctrl_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [31:0] scratch_m;
  logic [7:0]  ctrl_m;
  logic [31:0] count_m;
  localparam logic [31:0] ID_M = 32'hD47A_0001;

  always #5 clk = ~clk;

  dataplane_axil_regs dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .status_i(status_i), .ctrl_o(ctrl_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    scratch_m = 32'd0;
    ctrl_m    = 8'd0;
    count_m   = 32'd0;
  endfunction

  function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb);
    int off = int'(addr[7:0]) & 'hFC;
    if (off == 'h04) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) scratch_m[8*b +: 8] = data[8*b +: 8];
      count_m = count_m + 1;
      return 2'b00;
    end
    if (off == 'h08) begin
      if (strb[0]) ctrl_m = data[7:0];
      count_m = count_m + 1;
      return 2'b00;
    end
    return 2'b10;
  endfunction

  function automatic void m_read(input logic [31:0] addr, output logic [31:0] data,
                                 output logic [1:0] resp);
    int off = int'(addr[7:0]) & 'hFC;
    resp = 2'b00;
    case (off)
      'h00: data = ID_M;
      'h04: data = scratch_m;
      'h08: data = {24'd0, ctrl_m};
      'h0C: data = status_i;
      'h10: data = count_m;
      default: begin data = 32'd0; resp = 2'b10; end
    endcase
  endfunction

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, fire_aw, fire_w;
    int cyc = 0;
    wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b0;
    if (w_lead == 0) begin awaddr = addr; awvalid = 1'b1; end
    while (!(aw_done && w_done) && cyc < 64) begin
      fire_aw = awvalid && awready;
      fire_w  = wvalid && wready;
      @(negedge clk); cyc++;
      if (fire_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (fire_w)  begin wvalid  = 1'b0; w_done  = 1; end
      if (!aw_done && !awvalid && cyc >= w_lead) begin awaddr = addr; awvalid = 1'b1; end
    end
    check("wr_accept", {31'd0, aw_done && w_done}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; cyc = 0;
    while (!bvalid && cyc < 64) begin @(negedge clk); cyc++; end
    check("bvalid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_single", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int stall,
                          output logic [31:0] data, output logic [1:0] resp);
    bit done = 0, fire;
    int cyc = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    while (!done && cyc < 64) begin
      fire = arvalid && arready;
      @(negedge clk); cyc++;
      if (fire) begin arvalid = 1'b0; done = 1; end
    end
    check("ar_accept", {31'd0, done}, 32'd1);
    arvalid = 1'b0; cyc = 0;
    while (!rvalid && cyc < 64) begin @(negedge clk); cyc++; end
    check("rvalid_seen", {31'd0, rvalid}, 32'd1);
    data = rdata; resp = rresp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_rvalid", {31'd0, rvalid}, 32'd1);
      check("stall_rdata", rdata, data);
      check("stall_arready", {31'd0, arready}, 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_drop", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic wr_check(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead);
    logic [1:0] resp, eresp;
    axi_write(addr, data, strb, w_lead, resp);
    eresp = m_write(addr, data, strb);
    check({tag, "_bresp"}, {30'd0, resp}, {30'd0, eresp});
    check({tag, "_ctrl_o"}, {24'd0, ctrl_o}, {24'd0, ctrl_m});
    $display("WR %-10s addr=%h data=%h strb=%h lead=%0d bresp=%0d", tag, addr, data, strb, w_lead, resp);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input int stall);
    logic [31:0] data, edata;
    logic [1:0]  resp, eresp;
    m_read(addr, edata, eresp);
    axi_read(addr, stall, data, resp);
    check({tag, "_rdata"}, data, edata);
    check({tag, "_rresp"}, {30'd0, resp}, {30'd0, eresp});
    $display("RD %-10s addr=%h rdata=%h rresp=%0d", tag, addr, data, resp);
  endtask

  initial begin
    logic [31:0] a, d, old_scratch, rd_d;
    logic [1:0]  wr_r, rd_r;
    int          cyc;

    rst = 1'b1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; status_i = 32'h0BAD_F00D;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready",  {31'd0, wready},  32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_resp",    {28'd0, bresp, rresp}, 32'd0);
    check("rst_rdata",   rdata, 32'd0);
    check("rst_ctrl_o",  {24'd0, ctrl_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    rd_check("id", 32'h00, 0);
    rd_check("scratch0", 32'h04, 0);

    wr_check("scr_aa", 32'h04, 32'hAAAA_AAAA, 4'hF, 0);
    repeat (10) @(negedge clk);
    rd_check("scr_aa", 32'h04, 0);
    rd_check("count1", 32'h10, 0);

    wr_check("scr_zero", 32'h04, 32'h0, 4'hF, 3);
    wr_check("scr_strb5", 32'h04, 32'h1234_5678, 4'h5, 0);
    rd_check("scr_strb5", 32'h04, 0);
    check("scr_strb5_const", scratch_m, 32'h0034_0078);

    wr_check("ctrl_ff", 32'h08, 32'h0000_00FF, 4'hF, 0);
    rd_check("ctrl_ff", 32'h08, 0);
    wr_check("id_ro", 32'h00, 32'h5555_5555, 4'hF, 1);
    rd_check("id_after", 32'h00, 0);
    rd_check("count_ro", 32'h10, 0);
    wr_check("strb0", 32'h04, 32'hFFFF_FFFF, 4'h0, 2);
    rd_check("strb0", 32'h04, 0);
    rd_check("count_s0", 32'h10, 0);

    rd_check("unmapped", 32'h40, 5);
    status_i = 32'hC0DE_1234;
    rd_check("status", 32'h0C, 2);

    // Read and write of SCRATCH launched together: the read sees the old value
    old_scratch = scratch_m;
    fork
      axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, wr_r);
      axi_read(32'h04, 0, rd_d, rd_r);
    join
    check("rw_same_old", rd_d, old_scratch);
    check("rw_same_bresp", {30'd0, wr_r}, {30'd0, m_write(32'h04, 32'hDEAD_BEEF, 4'hF)});
    $display("RW same-cycle rdata=%h bresp=%0d", rd_d, wr_r);
    rd_check("rw_new", 32'h04, 0);

    for (int it = 0; it < 40; it++) begin
      int sel = int'($urandom_range(0, 6));
      a = $urandom;
      if (sel < 5) a[7:2] = 6'(sel);
      else a[7:2] = 6'($urandom_range(5, 63));
      status_i = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        wr_check("rand_wr", a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end else begin
        rd_check("rand_rd", a, int'($urandom_range(0, 2)));
      end
    end

    // Reset while a B response and an R response are both pending
    wr_check("ctrl_5a", 32'h08, 32'h0000_005A, 4'h1, 0);
    awaddr = 32'h04; awvalid = 1; wdata = 32'h1357_9BDF; wstrb = 4'hF; wvalid = 1; bready = 0;
    araddr = 32'h10; arvalid = 1; rready = 0;
    cyc = 0;
    while (!(bvalid && rvalid) && cyc < 32) begin
      @(negedge clk); cyc++;
      if (!awready) awvalid = 0;
      if (!wready)  wvalid  = 0;
      if (!arready) arvalid = 0;
    end
    check("pre_rst_pending", {30'd0, bvalid, rvalid}, 32'd3);
    awvalid = 0; wvalid = 0; arvalid = 0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
    check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    check("midrst_ctrl_o", {24'd0, ctrl_o}, 32'd0);
    check("midrst_rdata",  rdata, 32'd0);
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    check("post_rst_bvalid", {31'd0, bvalid}, 32'd0);
    rd_check("post_rst_scr", 32'h04, 0);
    rd_check("post_rst_cnt", 32'h10, 0);
    rd_check("post_rst_ctrl", 32'h08, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dataplane_axil_regs.md
Name: dataplane_axil_regs

Overview:
AXI4-Lite slave register bank. It terminates the control-plane AXI4-Lite bus that the dataplane testcases and the PS drive, and exposes scratch, control and status registers to the dataplane logic. It sits directly downstream of the AXI4-Lite master (the axi_lite_if driver) and upstream of the dataplane control inputs.

Parameters:
ADDR_W, 32, AXI address width; decode uses addr[7:2], addr[1:0] ignored, addr[ADDR_W-1:8] ignored
CTRL_W, 8, width of the CTRL register and the ctrl_o output
ID_VALUE, 32'hD47A_0001, constant returned by the ID register

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
s_axil_awaddr  in  ADDR_W  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte enables
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_W  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
status_i  in  32  live dataplane status word
ctrl_o  out  CTRL_W  registered CTRL value to the dataplane

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: awready, wready, arready, bvalid and rvalid are 0. bresp, rresp and rdata are 0. SCRATCH, CTRL, WR_COUNT and ctrl_o are 0.
- Register map:
  - 0x00 ID: read-only, returns ID_VALUE.
  - 0x04 SCRATCH: read/write, 32 bits.
  - 0x08 CTRL: read/write, bits [CTRL_W-1:0]; upper bits read as 0.
  - 0x0C STATUS: read-only, returns status_i as sampled in the AR handshake cycle.
  - 0x10 WR_COUNT: read-only, counts OKAY writes, 32-bit, wraps from 0xFFFFFFFF to 0.
  - All other offsets are unmapped.
- Write path FSM, states W_IDLE, W_RESP:
  - awready=1 in W_IDLE while the address is not yet latched. wready=1 in W_IDLE while the data is not yet latched.
  - AW and W are accepted in either order or in the same cycle. Each is latched independently.
  - In the cycle both are held, the write executes: per-byte wstrb update of the target. WR_COUNT increments on an OKAY write.
  - bvalid is asserted on the next cycle, entering W_RESP.
  - bvalid and bresp are held until bready=1, then the FSM returns to W_IDLE. bvalid && bready in the same cycle counts as the handshake.
  - No AW or W is accepted while in W_RESP.
  - A write to an RO or unmapped offset returns bresp=SLVERR, leaves no state changed and does not increment WR_COUNT.
  - wstrb=0 on a valid RW offset is OKAY and changes no data bits, but still increments WR_COUNT.
  - A CTRL write updates ctrl_o in the same cycle as the register.
- Read path FSM, states R_IDLE, R_DATA:
  - arready=1 in R_IDLE.
  - On AR handshake, rdata and rresp are registered and rvalid=1 on the next cycle.
  - rdata/rresp are held stable until rready=1; no AR is accepted in R_DATA.
  - An unmapped read returns rdata=0 and rresp=SLVERR.
  - Maximum throughput is one read every 2 cycles and one write every 2 cycles. The read and write paths are independent and concurrent.
- Simultaneous read and write of the same register: read data is taken from the pre-write value in the same cycle. The new value is visible to the next read.
- Reset mid-transaction: any latched AW/W and pending responses are discarded. All outputs return to reset values in the cycle after rst is sampled high. No response is issued for a discarded transaction.
- Master holding bready=0 or rready=0 indefinitely: the block stalls only that channel, with no data loss.

Test Plan:
- Reset, then read 0x00 -> rdata=0xD47A0001, rresp=00; read 0x04 -> 0x00000000.
- Write 0xAAAAAAAA to 0x04 with wstrb=0xF, wait 10 cycles, read 0x04 -> 0xAAAAAAAA, OKAY; then read 0x10 -> 1.
- W presented 3 cycles before AW, then AW and W presented in the same cycle -> exactly one bvalid per write. Write 0x12345678 with wstrb=0x5 over SCRATCH=0 -> readback 0x00340078.
- Write 0xFF to 0x08 -> ctrl_o=0xFF after the write cycle, readback 0x000000FF. Write to 0x00 -> SLVERR, ID unchanged, WR_COUNT unchanged.
- Read 0x40 -> rdata=0, rresp=SLVERR. Hold rready=0 for 5 cycles -> rvalid and rdata stable, arready=0 throughout.
- Assert rst while bvalid=1 and an AR is pending -> next cycle bvalid=rvalid=0, SCRATCH=0, ctrl_o=0, WR_COUNT=0.
